mc_ctrl_add: RTL and testbench
==============================

Name: mc_ctrl_add

Overview:
- Multicycle control FSM that drives the datapath control inputs of the add-subset CPU top: PC, memory, IR, register bank, A/B, ALU and operand muxes.
- Consumes the opcode/funct fields from the instruction register and the ALU flags.
- Produces every write enable, mux select and ALU code, plus a registered reset pulse to the datapath.
- Supports ADD (R-type) and ADDI, with overflow trap and illegal-opcode halt.

Parameters:
- MEM_WAIT, 1, number of cycles between a stable PC address and valid memory read data; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- overflow  in  1  ALU overflow flag (combinational, current cycle)
- negativo, zero, equal, gt, lt  in  1 each  ALU flags; unused by this subset, must not affect state
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- pc_write  out  1  PC load enable
- mem_write  out  1  memory write enable; always 0 in this subset
- ir_write  out  1  IR load enable
- rb_write  out  1  register bank write enable
- ab_write  out  1  A/B register load enable
- ula_control  out  3  ALU op: 000 load, 001 add, others unused
- m_wreg  out  2  write-register select: 00 rt, 01 rd, 10/11 reserved
- m_ula_a  out  1  ALU A select: 0 PC, 1 A
- m_ula_b  out  2  ALU B select: 00 B, 01 constant 4, 10 sign-extended immediate, 11 reserved
- reset_out  out  1  datapath reset pulse
- ovf_trap  out  1  sticky overflow trap indicator
- illegal_op  out  1  sticky illegal-opcode indicator
- state_dbg  out  3  current state code

Behaviour:
- Shared output rules:
  - All outputs are Moore, decoded from state and wait counter.
  - Exception: rb_write in the EXEC states is gated combinationally by overflow.
  - Any output not listed for a state is 0.
- States and encodings: RST=0, FETCH=1, DECODE=2, ADD_EX=3, ADDI_EX=4, OVF=5, ILL=6.
- Reset:
  - Asserting reset immediately forces state RST, wait_cnt=0 and all outputs 0 except reset_out=1.
  - This holds in every state, including mid-FETCH and mid-EXEC; partial fetches are discarded.
- RST: reset_out=1. On the first clock edge with reset low, go to FETCH.
- FETCH:
  - Every cycle drives m_ula_a=0, m_ula_b=01, ula_control=001.
  - wait_cnt counts 0..MEM_WAIT.
  - While wait_cnt<MEM_WAIT: no enables; wait_cnt increments.
  - When wait_cnt==MEM_WAIT: pc_write=1 and ir_write=1 in the same cycle; wait_cnt clears; next state DECODE.
  - PC must not be written earlier, because memory is addressed by PC.
  - FETCH lasts MEM_WAIT+1 cycles.
- DECODE: ab_write=1 for one cycle. Dispatch on the registered opcode/funct seen this cycle:
  - opcode=6'h00 and funct=6'h20 -> ADD_EX
  - opcode=6'h08 -> ADDI_EX
  - anything else -> ILL
- ADD_EX:
  - Drives m_ula_a=1, m_ula_b=00, ula_control=001, m_wreg=01, rb_write=~overflow.
  - Next state: OVF if overflow, else FETCH.
- ADDI_EX:
  - Drives m_ula_a=1, m_ula_b=10, ula_control=001, m_wreg=00, rb_write=~overflow.
  - Next state: OVF if overflow, else FETCH.
- OVF: ovf_trap=1. Terminal; held until reset. No write enables asserted.
- ILL: illegal_op=1. Terminal; held until reset. No write enables asserted.
- Latency: ADD/ADDI take MEM_WAIT+3 cycles per instruction (4 at default).
- Enable exclusivity: pc_write, ir_write, ab_write and rb_write are never asserted simultaneously except the pc_write+ir_write pair in FETCH.
- Boundaries:
  - Flags other than overflow are ignored in all states.
  - Overflow is ignored outside the EXEC states.
  - An X or reserved mux code never appears on outputs.

Decomposition:
- Shared package mc_ctrl_pkg:
  - state encodings
  - ALU codes (ULA_LOAD=000, ULA_ADD=001)
  - mux select constants for m_wreg, m_ula_a, m_ula_b
  - OP_RTYPE=6'h00, OP_ADDI=6'h08, FN_ADD=6'h20
- One natural sub-module, mc_ctrl_decode: combinational opcode/funct -> next-state dispatch.
- The FSM and wait counter stay in mc_ctrl_add.

Test Plan:
- Reset/boot: reset high 3 cycles, then low -> reset_out=1 throughout and for one cycle after; all enables 0; FETCH entered one cycle after deassert; state_dbg=1.
- ADD, MEM_WAIT=2: opcode=0, funct=0x20, overflow=0 -> FETCH for 3 cycles with pc_write=ir_write=1 only in the 3rd; then ab_write=1 for 1 cycle; then rb_write=1, m_wreg=01, m_ula_b=00, ula_control=001; then back to FETCH (5-cycle period).
- ADDI, default MEM_WAIT: opcode=0x08 -> 4-cycle instruction; EXEC drives m_ula_b=10, m_wreg=00, rb_write=1.
- Overflow: ADD_EX with overflow=1 -> rb_write=0 that cycle; next cycle ovf_trap=1, state_dbg=5; all enables stay 0 for 20 cycles.
- Illegal: opcode=0x23 (or opcode=0, funct=0x22) at DECODE -> ILL; illegal_op=1 held; no pc_write afterward.
- Mid-op reset: assert reset in FETCH wait cycle 1 -> same-cycle (asynchronous) drop of all enables, reset_out=1; after release, a full FETCH of MEM_WAIT+1 cycles restarts from wait_cnt=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the add-subset multicycle controller.
// Holds the FSM state encoding (visible on state_dbg), ALU operation codes,
// operand/write-register mux selects and the opcode/funct values decoded.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_ADD_EX  = 3'd3,
    ST_ADDI_EX = 3'd4,
    ST_OVF     = 3'd5,
    ST_ILL     = 3'd6
  } state_t;

  localparam logic [2:0] ULA_LOAD   = 3'b000;
  localparam logic [2:0] ULA_ADD    = 3'b001;

  localparam logic [1:0] WREG_RT    = 2'b00;
  localparam logic [1:0] WREG_RD    = 2'b01;

  localparam logic       ULA_A_PC   = 1'b0;
  localparam logic       ULA_A_REG  = 1'b1;

  localparam logic [1:0] ULA_B_REG  = 2'b00;
  localparam logic [1:0] ULA_B_FOUR = 2'b01;
  localparam logic [1:0] ULA_B_IMM  = 2'b10;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] FN_ADD     = 6'h20;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction dispatch for the DECODE state.
// Ports:
//   opcode_i   - IR[31:26]
//   funct_i    - IR[5:0]
//   dispatch_o - state code to enter after DECODE (ADD_EX, ADDI_EX or ILL)
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] dispatch_o
);

  always_comb begin
    dispatch_o = ST_ILL;
    if (opcode_i == OP_RTYPE && funct_i == FN_ADD) begin
      dispatch_o = ST_ADD_EX;
    end else if (opcode_i == OP_ADDI) begin
      // funct bits belong to the immediate here and are not examined
      dispatch_o = ST_ADDI_EX;
    end
  end

endmodule

// File: rtl/mc_ctrl_add.sv
// Multicycle control FSM for the ADD/ADDI CPU subset.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   overflow          - ALU overflow, only honoured in the EXEC states
//   negativo..lt      - remaining ALU flags, not used by this subset
//   opcode, funct     - instruction fields from the IR
//   pc_write..ab_write, mem_write - datapath write enables
//   ula_control, m_wreg, m_ula_a, m_ula_b - ALU code and mux selects
//   reset_out         - datapath reset, high while in RST
//   ovf_trap, illegal_op - sticky terminal-state indicators
//   state_dbg         - current state code
// Outputs are Moore-decoded from state and wait counter; the only Mealy path
// is overflow suppressing rb_write in the EXEC states.
import mc_ctrl_pkg::*;

module mc_ctrl_add #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       overflow,
  input  logic       negativo,
  input  logic       zero,
  input  logic       equal,
  input  logic       gt,
  input  logic       lt,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       mem_write,
  output logic       ir_write,
  output logic       rb_write,
  output logic       ab_write,
  output logic [2:0] ula_control,
  output logic [1:0] m_wreg,
  output logic       m_ula_a,
  output logic [1:0] m_ula_b,
  output logic       reset_out,
  output logic       ovf_trap,
  output logic       illegal_op,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [2:0] dispatch;
  logic       unused_flags;

  assign unused_flags = ^{negativo, zero, equal, gt, lt};

  mc_ctrl_decode u_decode (
    .opcode_i   (opcode),
    .funct_i    (funct),
    .dispatch_o (dispatch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    rb_write    = 1'b0;
    ab_write    = 1'b0;
    ula_control = ULA_LOAD;
    m_wreg      = WREG_RT;
    m_ula_a     = ULA_A_PC;
    m_ula_b     = ULA_B_REG;
    reset_out   = 1'b0;
    ovf_trap    = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      ST_RST: begin
        reset_out = 1'b1;
        wait_d    = '0;
        state_d   = ST_FETCH;
      end
      ST_FETCH: begin
        // PC+4 is computed every cycle but only committed once memory data
        // is valid, since the memory address is the PC itself.
        m_ula_a     = ULA_A_PC;
        m_ula_b     = ULA_B_FOUR;
        ula_control = ULA_ADD;
        if (wait_q == WAIT_LAST) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          wait_d   = '0;
          state_d  = ST_DECODE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_DECODE: begin
        ab_write = 1'b1;
        state_d  = state_t'(dispatch);
      end
      ST_ADD_EX: begin
        m_ula_a     = ULA_A_REG;
        m_ula_b     = ULA_B_REG;
        ula_control = ULA_ADD;
        m_wreg      = WREG_RD;
        rb_write    = ~overflow;
        state_d     = overflow ? ST_OVF : ST_FETCH;
      end
      ST_ADDI_EX: begin
        m_ula_a     = ULA_A_REG;
        m_ula_b     = ULA_B_IMM;
        ula_control = ULA_ADD;
        m_wreg      = WREG_RT;
        rb_write    = ~overflow;
        state_d     = overflow ? ST_OVF : ST_FETCH;
      end
      ST_OVF: begin
        ovf_trap = 1'b1;
      end
      ST_ILL: begin
        illegal_op = 1'b1;
      end
      default: begin
        state_d = ST_RST;
        wait_d  = '0;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_ctrl_add.sv
module tb_mc_ctrl_add;

  typedef struct packed {
    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       rb_w;
    logic       ab_w;
    logic [2:0] ula;
    logic [1:0] wreg;
    logic       ula_a;
    logic [1:0] ula_b;
    logic       rst_o;
    logic       ovf;
    logic       ill;
    logic [2:0] st;
  } outs_t;

  typedef struct {
    int         sel;     // 0: MEM_WAIT=2 instance, 1: default instance
    logic [5:0] op;
    logic [5:0] fn;
    logic       ovf;     // overflow during EXEC
    logic       noise;   // overflow driven high outside EXEC
    logic [2:0] exp_st;  // state expected after DECODE
    logic       exp_rb;  // rb_write expected in EXEC
  } vec_t;

  logic clk, reset, overflow, negativo, zero, equal, gt, lt;
  logic [5:0] opcode, funct;

  logic a_pc_write, a_mem_write, a_ir_write, a_rb_write, a_ab_write;
  logic [2:0] a_ula_control; logic [1:0] a_m_wreg; logic a_m_ula_a; logic [1:0] a_m_ula_b;
  logic a_reset_out, a_ovf_trap, a_illegal_op; logic [2:0] a_state_dbg;
  logic b_pc_write, b_mem_write, b_ir_write, b_rb_write, b_ab_write;
  logic [2:0] b_ula_control; logic [1:0] b_m_wreg; logic b_m_ula_a; logic [1:0] b_m_ula_b;
  logic b_reset_out, b_ovf_trap, b_illegal_op; logic [2:0] b_state_dbg;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  outs_t sb[$];

  mc_ctrl_add #(.MEM_WAIT(2)) dut_a (
    .clk(clk), .reset(reset), .overflow(overflow), .negativo(negativo), .zero(zero),
    .equal(equal), .gt(gt), .lt(lt), .opcode(opcode), .funct(funct),
    .pc_write(a_pc_write), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .rb_write(a_rb_write), .ab_write(a_ab_write), .ula_control(a_ula_control),
    .m_wreg(a_m_wreg), .m_ula_a(a_m_ula_a), .m_ula_b(a_m_ula_b),
    .reset_out(a_reset_out), .ovf_trap(a_ovf_trap), .illegal_op(a_illegal_op),
    .state_dbg(a_state_dbg)
  );

  mc_ctrl_add dut_b (
    .clk(clk), .reset(reset), .overflow(overflow), .negativo(negativo), .zero(zero),
    .equal(equal), .gt(gt), .lt(lt), .opcode(opcode), .funct(funct),
    .pc_write(b_pc_write), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .rb_write(b_rb_write), .ab_write(b_ab_write), .ula_control(b_ula_control),
    .m_wreg(b_m_wreg), .m_ula_a(b_m_ula_a), .m_ula_b(b_m_ula_b),
    .reset_out(b_reset_out), .ovf_trap(b_ovf_trap), .illegal_op(b_illegal_op),
    .state_dbg(b_state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t o;
    if (sel == 0)
      o = {a_pc_write, a_mem_write, a_ir_write, a_rb_write, a_ab_write, a_ula_control,
           a_m_wreg, a_m_ula_a, a_m_ula_b, a_reset_out, a_ovf_trap, a_illegal_op, a_state_dbg};
    else
      o = {b_pc_write, b_mem_write, b_ir_write, b_rb_write, b_ab_write, b_ula_control,
           b_m_wreg, b_m_ula_a, b_m_ula_b, b_reset_out, b_ovf_trap, b_illegal_op, b_state_dbg};
    return o;
  endfunction

  // Expected output records, written from the state descriptions
  function automatic outs_t e_rst();
    outs_t o = '0; o.rst_o = 1'b1; o.st = 3'd0; return o;
  endfunction
  function automatic outs_t e_fetch(input logic last);
    outs_t o = '0;
    o.ula = 3'b001; o.ula_a = 1'b0; o.ula_b = 2'b01; o.st = 3'd1;
    o.pc_w = last; o.ir_w = last;
    return o;
  endfunction
  function automatic outs_t e_dec();
    outs_t o = '0; o.ab_w = 1'b1; o.st = 3'd2; return o;
  endfunction
  function automatic outs_t e_exec(input logic [2:0] st, input logic rb);
    outs_t o = '0;
    o.ula = 3'b001; o.ula_a = 1'b1; o.rb_w = rb; o.st = st;
    if (st == 3'd3) begin o.wreg = 2'b01; o.ula_b = 2'b00; end
    else begin o.wreg = 2'b00; o.ula_b = 2'b10; end
    return o;
  endfunction
  function automatic outs_t e_ovf();
    outs_t o = '0; o.ovf = 1'b1; o.st = 3'd5; return o;
  endfunction
  function automatic outs_t e_ill();
    outs_t o = '0; o.ill = 1'b1; o.st = 3'd6; return o;
  endfunction

  task automatic compare(input string nm);
    outs_t got, exp;
    got = sample();
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %05h required %05h", nm, sel, got, exp);
    end
  endtask

  // One clock: drive inputs, queue expectation, compare at negedge,
  // then step to just after the next rising edge.
  task automatic cyc(input outs_t e, input logic ovf, input string nm);
    overflow = ovf;
    {negativo, zero, equal, gt, lt} = 5'($urandom);
    sb.push_back(e);
    @(negedge clk);
    compare(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    cyc(e_rst(), 1'b0, "rst_hold");
    reset = 1'b0;
    cyc(e_rst(), 1'b0, "rst_release");
  endtask

  vec_t vecs[9];

  initial begin
    int mw;
    reset = 1'b1; overflow = 1'b0; opcode = '0; funct = '0;
    {negativo, zero, equal, gt, lt} = '0;
    #1;

    // Boot: reset held 3 cycles, reset_out stays one cycle after release
    sel = 0;
    for (int i = 0; i < 3; i++) cyc(e_rst(), 1'b0, "boot_rst");
    reset = 1'b0;
    opcode = 6'h00; funct = 6'h20;
    cyc(e_rst(), 1'b0, "boot_release");
    cyc(e_fetch(1'b0), 1'b0, "boot_fetch");

    vecs[0] = '{0, 6'h00, 6'h20, 1'b0, 1'b0, 3'd3, 1'b1};
    vecs[1] = '{0, 6'h08, 6'h15, 1'b0, 1'b1, 3'd4, 1'b1};
    vecs[2] = '{1, 6'h08, 6'h20, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[3] = '{1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd3, 1'b1};
    vecs[4] = '{0, 6'h00, 6'h20, 1'b1, 1'b0, 3'd3, 1'b0};
    vecs[5] = '{1, 6'h08, 6'h00, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[6] = '{0, 6'h23, 6'h20, 1'b0, 1'b1, 3'd6, 1'b0};
    vecs[7] = '{1, 6'h00, 6'h22, 1'b0, 1'b0, 3'd6, 1'b0};
    vecs[8] = '{0, 6'h20, 6'h20, 1'b0, 1'b0, 3'd6, 1'b0};

    foreach (vecs[k]) begin
      sel = vecs[k].sel;
      mw = (sel == 0) ? 2 : 1;
      opcode = vecs[k].op;
      funct = vecs[k].fn;
      rst_pulse();
      for (int i = 0; i <= mw; i++) cyc(e_fetch(i == mw), vecs[k].noise, "fetch");
      cyc(e_dec(), vecs[k].noise, "decode");
      if (vecs[k].exp_st == 3'd6) begin
        for (int i = 0; i < 8; i++) cyc(e_ill(), 1'($urandom), "ill_hold");
      end else begin
        cyc(e_exec(vecs[k].exp_st, vecs[k].exp_rb), vecs[k].ovf, "exec");
        if (vecs[k].ovf) begin
          for (int i = 0; i < 20; i++) cyc(e_ovf(), 1'($urandom), "ovf_hold");
        end else begin
          // next instruction restarts the fetch with a fresh wait count
          cyc(e_fetch(1'b0), vecs[k].noise, "refetch");
          for (int i = 1; i <= mw; i++) cyc(e_fetch(i == mw), 1'b0, "refetch2");
          cyc(e_dec(), 1'b0, "redecode");
        end
      end
    end

    // Reset in FETCH wait cycle 1: asynchronous drop, then full refetch
    sel = 0;
    opcode = 6'h00; funct = 6'h20;
    rst_pulse();
    cyc(e_fetch(1'b0), 1'b0, "mid_fetch0");
    reset = 1'b1;
    #1;
    sb.push_back(e_rst());
    compare("mid_rst_async");
    @(posedge clk);
    #1;
    cyc(e_rst(), 1'b0, "mid_rst_hold");
    reset = 1'b0;
    cyc(e_rst(), 1'b0, "mid_rst_release");
    cyc(e_fetch(1'b0), 1'b0, "mid_refetch0");
    cyc(e_fetch(1'b0), 1'b0, "mid_refetch1");
    cyc(e_fetch(1'b1), 1'b0, "mid_refetch2");
    cyc(e_dec(), 1'b0, "mid_decode");
    cyc(e_exec(3'd3, 1'b1), 1'b0, "mid_exec");

    // Reset while trapped in ILL must recover
    sel = 1;
    opcode = 6'h3f;
    rst_pulse();
    cyc(e_fetch(1'b0), 1'b0, "ill2_fetch0");
    cyc(e_fetch(1'b1), 1'b0, "ill2_fetch1");
    cyc(e_dec(), 1'b0, "ill2_decode");
    cyc(e_ill(), 1'b0, "ill2_hold");
    opcode = 6'h08;
    rst_pulse();
    cyc(e_fetch(1'b0), 1'b0, "rec_fetch0");
    cyc(e_fetch(1'b1), 1'b0, "rec_fetch1");
    cyc(e_dec(), 1'b0, "rec_decode");
    cyc(e_exec(3'd4, 1'b1), 1'b0, "rec_exec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
